bcd_up_down_counter: RTL and testbench

BCD_UP_DOWN_COUNTER -- requirements
Module: bcd_up_down_counter

---
 rtl/bcd_up_down_counter.sv | 156 +++++++++++++++
 tb/tb_bcd_up_down_counter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bcd_up_down_counter.sv
// bcd_up_down_counter
//   Two-digit BCD up/down counter with run/stop and clear push buttons.
//   Buttons are synchronised, debounced and edge-detected; a prescaler
//   divides clk down to the count tick while the FSM is in RUN.
//
// Parameters
//   AW        width of addr (tens digit in [7:4], units digit in [3:0])
//   TICK_DIV  clk cycles per count step
//   DEBOUNCE  cycles a button must be stable before it is accepted
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-low reset
//   btn_run  in   raw button, each accepted press toggles run/stop
//   btn_clr  in   raw button, each accepted press clears the count
//   dir      in   1 = count up, 0 = count down (sampled at each tick)
//   addr     out  BCD count
//   running  out  high while in RUN
//   wrap     out  one-cycle pulse on 99->00 (up) or 00->99 (down)
module bcd_up_down_counter #(
  parameter int AW       = 8,
  parameter int TICK_DIV = 12000000,
  parameter int DEBOUNCE = 120000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          btn_run,
  input  logic          btn_clr,
  input  logic          dir,
  output logic [AW-1:0] addr,
  output logic          running,
  output logic          wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE - 1);

  typedef enum logic {STOP, RUN} state_t;

  // Bit 0 carries btn_run, bit 1 carries btn_clr throughout the button path.
  logic [1:0]    sync_p0, sync_p1;
  logic [1:0]    db_lvl, db_lvl_q;
  logic [DW-1:0] db_cnt [2];
  logic          run_ev, clr_ev;

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic          tick;
  logic [7:0]    cnt;

  // Saturating-safe BCD step helpers: any out-of-range digit folds back
  // into 0..9, so addr can never show a non-BCD nibble.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] u, t;
    u = v[3:0];
    t = v[7:4];
    if (u >= 4'd9) begin
      u = 4'd0;
      t = (t >= 4'd9) ? 4'd0 : t + 4'd1;
    end else begin
      u = u + 4'd1;
    end
    return {t, u};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [3:0] u, t;
    u = v[3:0];
    t = v[7:4];
    if (u == 4'd0 || u > 4'd9) begin
      u = 4'd9;
      t = (t == 4'd0 || t > 4'd9) ? 4'd9 : t - 4'd1;
    end else begin
      u = u - 4'd1;
    end
    return {t, u};
  endfunction

  // ---- stage p0/p1: two-flop synchroniser, then debounce ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      db_lvl    <= '0;
      db_lvl_q  <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync_p0  <= {btn_clr, btn_run};
      sync_p1  <= sync_p0;
      db_lvl_q <= db_lvl;
      for (int i = 0; i < 2; i++) begin
        // Any cycle where the input agrees with the level restarts the count.
        if (sync_p1[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          db_lvl[i] <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Rising edge of the debounced level only; a held button fires once.
  assign run_ev = db_lvl[0] & ~db_lvl_q[0];
  assign clr_ev = db_lvl[1] & ~db_lvl_q[1];

  // ---- run/stop FSM ----
  always_ff @(posedge clk) begin
    if (!reset) state <= STOP;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (run_ev) state_nxt = (state == STOP) ? RUN : STOP;
  end

  assign running = (state == RUN);
  assign tick    = (state == RUN) && (presc == PRESC_MAX);

  // ---- prescaler and BCD count ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc <= '0;
      cnt   <= 8'h00;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr_ev) begin
        // Clear beats a coincident tick: no count, no wrap.
        presc <= '0;
        cnt   <= 8'h00;
      end else begin
        // In STOP the prescaler holds so a resume finishes the partial period.
        if (state == RUN) presc <= tick ? '0 : presc + PW'(1);
        if (tick) begin
          if (dir) begin
            cnt  <= bcd_inc(cnt);
            wrap <= (cnt == 8'h99);
          end else begin
            cnt  <= bcd_dec(cnt);
            wrap <= (cnt == 8'h00);
          end
        end
      end
    end
  end

  assign addr = AW'(cnt);

endmodule

// File: tb/tb_bcd_up_down_counter.sv
// tb_bcd_up_down_counter
//   Directed bench for bcd_up_down_counter with TICK_DIV=4, DEBOUNCE=3.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
//   A button driven high after edge E0 produces its event in the cycle
//   after E5, so its effect on registers appears at E6.
module tb_bcd_up_down_counter;

  logic       clk;
  logic       reset;
  logic       btn_run;
  logic       btn_clr;
  logic       dir;
  logic [7:0] addr;
  logic       running;
  logic       wrap;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_up_down_counter #(
    .AW       (8),
    .TICK_DIV (4),
    .DEBOUNCE (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_run (btn_run),
    .btn_clr (btn_clr),
    .dir     (dir),
    .addr    (addr),
    .running (running),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [9:0] pat;

  initial begin
    reset   = 1'b0;
    btn_run = 1'b0;
    btn_clr = 1'b0;
    dir     = 1'b1;
    pat     = 10'b1111111011;

    // Reset held for two edges
    step(2);
    chk("rst_addr",    16'(addr),    16'h00);
    chk("rst_running", 16'(running), 16'h0);
    chk("rst_wrap",    16'(wrap),    16'h0);
    reset = 1'b1;
    step(1);
    chk("rel_addr",    16'(addr),    16'h00);
    chk("rel_running", 16'(running), 16'h0);

    // Run press with a one-cycle glitch low at cycle 2; RUN entered at E9
    for (int k = 0; k < 10; k++) begin
      btn_run = pat[k];
      step(1);
    end
    btn_run = 1'b0;
    chk("glitch_running", 16'(running), 16'h1);
    step(39);
    chk("count40_addr", 16'(addr), 16'h10);

    // Count up to 99, then wrap up, then wrap down
    step(356);
    chk("pre99_addr", 16'(addr), 16'h99);
    chk("pre99_wrap", 16'(wrap), 16'h0);
    step(3);
    chk("hold99_addr", 16'(addr), 16'h99);
    step(1);
    chk("wrapup_addr", 16'(addr), 16'h00);
    chk("wrapup_wrap", 16'(wrap), 16'h1);
    step(1);
    chk("wrapup_pulse_end", 16'(wrap), 16'h0);
    dir = 1'b0;
    step(3);
    chk("wrapdn_addr", 16'(addr), 16'h99);
    chk("wrapdn_wrap", 16'(wrap), 16'h1);
    step(1);
    chk("wrapdn_pulse_end", 16'(wrap), 16'h0);

    // Clear while running (98 at this point), prescaler restarts from 0
    btn_clr = 1'b1;
    step(6);
    chk("clr_addr",    16'(addr),    16'h00);
    chk("clr_running", 16'(running), 16'h1);
    btn_clr = 1'b0;

    // Stop at prescaler=2 with addr=09, then resume
    dir = 1'b1;
    step(32);
    btn_run = 1'b1;
    step(4);
    chk("at09_addr",    16'(addr),    16'h09);
    chk("at09_running", 16'(running), 16'h1);
    step(2);
    chk("stop_running", 16'(running), 16'h0);
    btn_run = 1'b0;
    step(20);
    chk("stop_hold_addr", 16'(addr),    16'h09);
    chk("stop_hold_run",  16'(running), 16'h0);
    btn_run = 1'b1;
    step(6);
    chk("resume_running", 16'(running), 16'h1);
    chk("resume_addr",    16'(addr),    16'h09);
    btn_run = 1'b0;
    step(1);
    chk("resume_1cyc_addr", 16'(addr), 16'h09);
    step(1);
    chk("resume_2cyc_addr", 16'(addr), 16'h10);

    // Clear event coinciding with the tick that would make 45
    step(134);
    btn_clr = 1'b1;
    step(5);
    chk("pre_clr44_addr", 16'(addr), 16'h44);
    step(1);
    chk("clrtick_addr",    16'(addr),    16'h00);
    chk("clrtick_wrap",    16'(wrap),    16'h0);
    chk("clrtick_running", 16'(running), 16'h1);
    btn_clr = 1'b0;
    step(4);
    chk("after_clr_addr", 16'(addr), 16'h01);

    // One-cycle reset while running at 37 with btn_run held
    step(142);
    btn_run = 1'b1;
    step(2);
    chk("at37_addr", 16'(addr), 16'h37);
    reset = 1'b0;
    step(1);
    chk("midrst_addr",    16'(addr),    16'h00);
    chk("midrst_running", 16'(running), 16'h0);
    chk("midrst_wrap",    16'(wrap),    16'h0);
    reset = 1'b1;
    step(5);
    chk("no_early_ev", 16'(running), 16'h0);
    step(1);
    chk("held_ev_after_db", 16'(running), 16'h1);
    btn_run = 1'b0;
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
